// File: rtl/mkio_line_select.sv
// mkio_line_select
//   Selects between the main (A) and reserve (B) line pairs of a dual-redundant
//   Manchester bus. Incoming line pairs are synchronized (and optionally
//   deglitched); the first channel showing activity is locked and routed to
//   the receiver. While the transmitter is busy, its Manchester pair is routed
//   to the last locked channel only. A short guard time after transmission
//   ends keeps the lines owned before returning to IDLE.
//
//   Build option: define MKIO_GLITCH_FILTER_EN to add a 3-sample glitch filter
//   after the synchronizers (input-to-DI latency 5 clocks instead of 2).
//
// Ports
//   clk, reset                 : system clock, asynchronous active-high reset
//   DI1A/DI0A, DI1B/DI0B       : raw receive lines, channel A and channel B
//   DI1/DI0                    : selected filtered pair to the receiver
//   DO1/DO0, tx_busy           : transmitter Manchester pair and busy flag
//   DO1A/DO0A, DO1B/DO0B       : per-channel transmit pairs
//   RX_STROB_A/B               : 1 = receiver enabled on that channel
//   TX_INHIBIT_A/B             : 1 = transmitter inhibited on that channel
//   chan_b                     : last locked channel (0 = A, 1 = B)
//   chan_active                : a channel is locked or transmitting
//   chan_conflict              : one-cycle pulse, activity on the unlocked channel
`timescale 1ns/1ps
module mkio_line_select (
  input  logic clk,
  input  logic reset,
  input  logic DI1A,
  input  logic DI0A,
  input  logic DI1B,
  input  logic DI0B,
  output logic DI1,
  output logic DI0,
  input  logic DO1,
  input  logic DO0,
  input  logic tx_busy,
  output logic DO1A,
  output logic DO0A,
  output logic DO1B,
  output logic DO0B,
  output logic RX_STROB_A,
  output logic RX_STROB_B,
  output logic TX_INHIBIT_A,
  output logic TX_INHIBIT_B,
  output logic chan_b,
  output logic chan_active,
  output logic chan_conflict
);

  typedef enum logic [1:0] {S_IDLE, S_LOCK_A, S_LOCK_B, S_TX} state_t;

  // The 63rd consecutive quiet clock releases a lock; the 15th clock after
  // tx_busy falls ends the guard time. Transitions fire on the clock at which
  // the counter would reach its terminal count.
  localparam logic [5:0] QUIET_LAST = 6'd62;
  localparam logic [3:0] GUARD_LAST = 4'd14;

  // Line bit order: [3]=A1 [2]=A0 [1]=B1 [0]=B0
  logic [3:0] w_raw;
  logic [3:0] r_sync_p0;
  logic [3:0] r_sync_p1;
  logic [3:0] w_filt;
  logic [3:0] r_filt_prev;
  logic       w_act_a;
  logic       w_act_b;
  logic       w_act_own;

  state_t     r_state;
  logic [5:0] r_qcnt;
  logic [3:0] r_gcnt;

  assign w_raw = {DI1A, DI0A, DI1B, DI0B};

  // Stage p0/p1: two-flop synchronizer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync_p0 <= '0;
      r_sync_p1 <= '0;
    end else begin
      r_sync_p0 <= w_raw;
      r_sync_p1 <= r_sync_p0;
    end
  end

`ifdef MKIO_GLITCH_FILTER_EN
  // Stage p2..p4: a line only takes a new value once the synchronizer output
  // and the two previous samples agree, so pulses of 1-2 clocks never pass.
  logic [3:0] r_hist_p2;
  logic [3:0] r_hist_p3;
  logic [3:0] r_filt_p4;
  logic [3:0] w_stable;

  assign w_stable = ~(r_sync_p1 ^ r_hist_p2) & ~(r_sync_p1 ^ r_hist_p3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hist_p2 <= '0;
      r_hist_p3 <= '0;
      r_filt_p4 <= '0;
    end else begin
      r_hist_p2 <= r_sync_p1;
      r_hist_p3 <= r_hist_p2;
      r_filt_p4 <= (r_sync_p1 & w_stable) | (r_filt_p4 & ~w_stable);
    end
  end

  assign w_filt = r_filt_p4;
`else
  assign w_filt = r_sync_p1;
`endif

  // Activity: any filtered line of a channel changed on the last clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_filt_prev <= '0;
    else       r_filt_prev <= w_filt;
  end

  assign w_act_a   = |(w_filt[3:2] ^ r_filt_prev[3:2]);
  assign w_act_b   = |(w_filt[1:0] ^ r_filt_prev[1:0]);
  assign w_act_own = (r_state == S_LOCK_A) ? w_act_a : w_act_b;

  // Line-selection FSM with registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_qcnt        <= '0;
      r_gcnt        <= '0;
      chan_b        <= 1'b0;
      chan_active   <= 1'b0;
      chan_conflict <= 1'b0;
      RX_STROB_A    <= 1'b1;
      RX_STROB_B    <= 1'b1;
      TX_INHIBIT_A  <= 1'b1;
      TX_INHIBIT_B  <= 1'b1;
    end else begin
      chan_conflict <= ((r_state == S_LOCK_A) && w_act_b) ||
                       ((r_state == S_LOCK_B) && w_act_a);
      case (r_state)
        S_IDLE, S_LOCK_A, S_LOCK_B: begin
          if (tx_busy) begin
            // Transmit on the channel held in chan_b; it is not changed here.
            r_state      <= S_TX;
            r_gcnt       <= '0;
            r_qcnt       <= '0;
            chan_active  <= 1'b1;
            RX_STROB_A   <= 1'b0;
            RX_STROB_B   <= 1'b0;
            TX_INHIBIT_A <= chan_b;
            TX_INHIBIT_B <= ~chan_b;
          end else if (r_state == S_IDLE) begin
            r_qcnt <= '0;
            if (w_act_a) begin
              r_state     <= S_LOCK_A;
              chan_b      <= 1'b0;
              chan_active <= 1'b1;
            end else if (w_act_b) begin
              r_state     <= S_LOCK_B;
              chan_b      <= 1'b1;
              chan_active <= 1'b1;
            end
          end else if (w_act_own) begin
            r_qcnt <= '0;
          end else if (r_qcnt == QUIET_LAST) begin
            r_state     <= S_IDLE;
            r_qcnt      <= '0;
            chan_active <= 1'b0;
          end else begin
            r_qcnt <= r_qcnt + 6'd1;
          end
        end
        S_TX: begin
          if (tx_busy) begin
            r_gcnt <= '0;
          end else if (r_gcnt == GUARD_LAST) begin
            r_state      <= S_IDLE;
            r_gcnt       <= '0;
            chan_active  <= 1'b0;
            RX_STROB_A   <= 1'b1;
            RX_STROB_B   <= 1'b1;
            TX_INHIBIT_A <= 1'b1;
            TX_INHIBIT_B <= 1'b1;
          end else begin
            r_gcnt <= r_gcnt + 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Receive mux: locked channel, OR of both while idle, silent while sending
  always_comb begin
    DI1 = 1'b0;
    DI0 = 1'b0;
    case (r_state)
      S_IDLE: begin
        DI1 = w_filt[3] | w_filt[1];
        DI0 = w_filt[2] | w_filt[0];
      end
      S_LOCK_A: begin
        DI1 = w_filt[3];
        DI0 = w_filt[2];
      end
      S_LOCK_B: begin
        DI1 = w_filt[1];
        DI0 = w_filt[0];
      end
      default: begin
        DI1 = 1'b0;
        DI0 = 1'b0;
      end
    endcase
  end

  // Transmit mux is gated by the asynchronously reset state register, so a
  // reset during transmission silences the lines without waiting for a clock.
  assign DO1A = (r_state == S_TX) && !chan_b && DO1;
  assign DO0A = (r_state == S_TX) && !chan_b && DO0;
  assign DO1B = (r_state == S_TX) &&  chan_b && DO1;
  assign DO0B = (r_state == S_TX) &&  chan_b && DO0;

endmodule

// File: tb/tb_mkio_line_select.sv
`timescale 1ns/1ps
module tb_mkio_line_select;

`ifdef MKIO_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 2;
`endif

  logic clk, reset;
  logic DI1A, DI0A, DI1B, DI0B, DI1, DI0;
  logic DO1, DO0, tx_busy;
  logic DO1A, DO0A, DO1B, DO0B;
  logic RX_STROB_A, RX_STROB_B, TX_INHIBIT_A, TX_INHIBIT_B;
  logic chan_b, chan_active, chan_conflict;

  int nchk = 0;
  int nfail = 0;

  mkio_line_select dut (
    .clk(clk), .reset(reset),
    .DI1A(DI1A), .DI0A(DI0A), .DI1B(DI1B), .DI0B(DI0B),
    .DI1(DI1), .DI0(DI0),
    .DO1(DO1), .DO0(DO0), .tx_busy(tx_busy),
    .DO1A(DO1A), .DO0A(DO0A), .DO1B(DO1B), .DO0B(DO0B),
    .RX_STROB_A(RX_STROB_A), .RX_STROB_B(RX_STROB_B),
    .TX_INHIBIT_A(TX_INHIBIT_A), .TX_INHIBIT_B(TX_INHIBIT_B),
    .chan_b(chan_b), .chan_active(chan_active), .chan_conflict(chan_conflict)
  );

  initial clk = 1'b0;
  always #15.625 clk = ~clk;

  typedef struct {
    logic sel_b;
    logic do1, do0;
    logic e1a, e0a, e1b, e0b;
  } vec_t;

  vec_t tbl [8];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_table(input logic sel);
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].sel_b == sel) begin
        DO1 = tbl[i].do1;
        DO0 = tbl[i].do0;
        #1;
        chk("do_tbl_1a", DO1A, tbl[i].e1a);
        chk("do_tbl_0a", DO0A, tbl[i].e0a);
        chk("do_tbl_1b", DO1B, tbl[i].e1b);
        chk("do_tbl_0b", DO0B, tbl[i].e0b);
      end
    end
    DO1 = 1'b0;
    DO0 = 1'b0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // {sel_b, DO1, DO0, DO1A, DO0A, DO1B, DO0B}
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    reset = 1'b1;
    DI1A = 0; DI0A = 0; DI1B = 0; DI0B = 0;
    DO1 = 0; DO0 = 0; tx_busy = 0;
    @(negedge clk);
    tick(2);

    // Reset state
    chk("rst_active", chan_active, 0);
    chk("rst_chan_b", chan_b, 0);
    chk("rst_conflict", chan_conflict, 0);
    chk("rst_rx_a", RX_STROB_A, 1);
    chk("rst_rx_b", RX_STROB_B, 1);
    chk("rst_inh_a", TX_INHIBIT_A, 1);
    chk("rst_inh_b", TX_INHIBIT_B, 1);
    chk("rst_di", {DI1, DI0}, 0);
    chk("rst_do", {DO1A, DO0A, DO1B, DO0B}, 0);
    reset = 1'b0;
    tick(2);

    // Glitch behaviour on DI1A
`ifdef MKIO_GLITCH_FILTER_EN
    for (int w = 1; w <= 2; w++) begin
      DI1A = 1'b1;
      tick(w);
      DI1A = 1'b0;
      for (int k = 0; k < LAT + 3; k++) begin
        tick(1);
        chk("glitch_di1", DI1, 0);
      end
      chk("glitch_no_lock", chan_active, 0);
    end
    DI1A = 1'b1;
    tick(3);
    DI1A = 1'b0;
    tick(1);
    chk("pulse3_early", DI1, 0);
    tick(1);
    chk("pulse3_pass", DI1, 1);
    tick(1);
    chk("pulse3_lock", chan_active, 1);
`else
    DI1A = 1'b1;
    tick(1);
    DI1A = 1'b0;
    chk("pulse1_early", DI1, 0);
    tick(1);
    chk("pulse1_pass", DI1, 1);
    tick(1);
    chk("pulse1_end", DI1, 0);
    chk("pulse1_lock", chan_active, 1);
`endif
    tick(80);
    chk("glitch_idle", chan_active, 0);
    chk("glitch_chan", chan_b, 0);

    // Transmit on channel A straight from IDLE
    tx_busy = 1'b1;
    tick(1);
    chk("txa_active", chan_active, 1);
    chk("txa_rx", {RX_STROB_A, RX_STROB_B}, 0);
    chk("txa_inh", {TX_INHIBIT_A, TX_INHIBIT_B}, 2'b01);
    run_table(1'b0);
    tx_busy = 1'b0;
    tick(14);
    chk("txa_guard", chan_active, 1);
    tick(1);
    chk("txa_idle", chan_active, 0);
    chk("txa_rx_back", {RX_STROB_A, RX_STROB_B}, 2'b11);
    chk("txa_inh_back", {TX_INHIBIT_A, TX_INHIBIT_B}, 2'b11);

    // A-only word, lock A, quiet release
    DI1A = 1'b1;
    tick(LAT - 1);
    chk("worda_lat_pre", DI1, 0);
    tick(1);
    chk("worda_lat", DI1, 1);
    tick(1);
    chk("worda_lock", chan_active, 1);
    chk("worda_chan", chan_b, 0);
    tick(3);
    DI1A = 1'b0;
    DI0A = 1'b1;
    tick(LAT - 1);
    chk("worda_hold", DI1, 1);
    tick(1);
    chk("worda_di", {DI1, DI0}, 2'b01);
    tick(63);
    chk("worda_quiet62", chan_active, 1);
    tick(1);
    chk("worda_release", chan_active, 0);
    chk("worda_idle_di", {DI1, DI0}, 2'b01);

    // Simultaneous A and B activity: A wins, B edges flag conflict
    DI1A = 1'b1;
    DI0A = 1'b0;
    DI0B = 1'b1;
    tick(LAT + 1);
    chk("simul_lock", chan_active, 1);
    chk("simul_chan", chan_b, 0);
    chk("simul_noconf", chan_conflict, 0);
    chk("simul_di_a", {DI1, DI0}, 2'b10);
    for (int e = 0; e < 2; e++) begin
      if (e == 0) DI0B = 1'b0;
      else        DI1B = 1'b1;
      tick(LAT);
      chk("conf_pre", chan_conflict, 0);
      tick(1);
      chk("conf_pulse", chan_conflict, 1);
      chk("conf_chan", chan_b, 0);
      tick(1);
      chk("conf_end", chan_conflict, 0);
      chk("conf_di_a", {DI1, DI0}, 2'b10);
    end
    tick(70);
    chk("simul_release", chan_active, 0);

    // Lock B, then long transmission on B
    DI1B = 1'b0;
    DI0B = 1'b1;
    tick(LAT + 1);
    chk("lockb_chan", chan_b, 1);
    chk("lockb_active", chan_active, 1);
    chk("lockb_di", {DI1, DI0}, 2'b01);
    tx_busy = 1'b1;
    tick(1);
    chk("txb_rx", {RX_STROB_A, RX_STROB_B}, 0);
    chk("txb_inh", {TX_INHIBIT_A, TX_INHIBIT_B}, 2'b10);
    chk("txb_chan", chan_b, 1);
    chk("txb_di", {DI1, DI0}, 0);
    run_table(1'b1);
    for (int i = 0; i < 630; i++) begin
      DO1 = ((i & 1) != 0);
      DO0 = ((i & 1) == 0);
      #1;
      if ((i % 90) == 0) begin
        chk("txb_mirror", {DO1A, DO0A, DO1B, DO0B}, {2'b00, ((i & 1) != 0), ((i & 1) == 0)});
      end
      tick(1);
    end
    DO1 = 1'b0;
    DO0 = 1'b0;
    tx_busy = 1'b0;
    tick(10);
    chk("guard_mid", chan_active, 1);
    tx_busy = 1'b1;
    tick(1);
    tx_busy = 1'b0;
    tick(14);
    chk("guard_restart", chan_active, 1);
    chk("guard_inh", TX_INHIBIT_B, 0);
    tick(1);
    chk("txb_idle", chan_active, 0);
    chk("txb_rx_back", {RX_STROB_A, RX_STROB_B}, 2'b11);
    chk("txb_inh_back", {TX_INHIBIT_A, TX_INHIBIT_B}, 2'b11);

    // Reset in the middle of a transmission
    tx_busy = 1'b1;
    DO1 = 1'b1;
    DO0 = 1'b0;
    tick(1);
    chk("rsttx_pre", {DO1B, DO0B}, 2'b10);
    DI1A = 0; DI0A = 0; DI1B = 0; DI0B = 0;
    #5;
    reset = 1'b1;
    #1;
    chk("rsttx_do", {DO1A, DO0A, DO1B, DO0B}, 0);
    chk("rsttx_inh", {TX_INHIBIT_A, TX_INHIBIT_B}, 2'b11);
    chk("rsttx_rx", {RX_STROB_A, RX_STROB_B}, 2'b11);
    tx_busy = 1'b0;
    DO1 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tick(2);
    chk("rsttx_idle", chan_active, 0);
    chk("rsttx_chan", chan_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
